// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared widths, branch record type and recovery FSM states
package branch_resolve_unit_pkg;
  localparam int BR_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [BR_XLEN-1:0] pc;
    logic               pred_taken;
    logic [BR_XLEN-1:0] pred_target;
  } br_rec_t;
  typedef enum logic {RUN, RECOVER} state_t;
endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// branch_record_fifo: circular buffer of in-flight branch predictions in program order
module branch_record_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  br_rec_t                din,
  output br_rec_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  br_rec_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wr_d = clear ? wr_q : wr_q + AW'(push);
    rd_d = clear ? wr_q : rd_q + AW'(pop);
    count_d = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q] <= din;
  end
  assign head = mem_q[rd_q];
  assign count = count_q;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks queued fetch predictions against execute outcomes,
// updates the predictor and redirects fetch on a mispredict.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = BR_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic            push_pred_taken,
  input  logic [XLEN-1:0] push_pred_target,
  output logic            full,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  input  logic            flush,
  output logic            update,
  output logic [XLEN-1:0] branchPC,
  output logic [XLEN-1:0] resultPC,
  output logic            taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            underflow_err
);
  state_t state_q, state_d;
  br_rec_t head;
  logic [$clog2(DEPTH):0] count;
  logic empty, run, resolve_now, mis_now, push_ok;
  logic [XLEN-1:0] result_now;
  logic update_q, update_d, taken_q, taken_d, mispredict_q, mispredict_d, underflow_q, underflow_d;
  logic [XLEN-1:0] branch_pc_q, branch_pc_d, result_pc_q, result_pc_d;
  branch_record_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(flush | mis_now),
    .push (push_ok),
    .pop  (resolve_now),
    .din  ('{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target}),
    .head (head),
    .count(count),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    run = state_q == RUN;
    resolve_now = resolve_valid & !empty & run & !flush;
    result_now = resolve_taken ? resolve_target : head.pc + XLEN'(INSTR_BYTES);
    mis_now = resolve_now & ((resolve_taken != head.pred_taken) | (result_now != head.pred_target));
    // a full queue still accepts a push when the head retires on the same edge
    push_ok = push & run & !flush & !mis_now & (!full | resolve_now);
    state_d = mis_now ? RECOVER : RUN;
    update_d = resolve_now;
    mispredict_d = mis_now;
    taken_d = resolve_now ? resolve_taken : taken_q;
    branch_pc_d = resolve_now ? head.pc : branch_pc_q;
    result_pc_d = resolve_now ? result_now : result_pc_q;
    underflow_d = underflow_q | (resolve_valid & empty & run & !flush);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      update_q <= 1'b0;
      mispredict_q <= 1'b0;
      taken_q <= 1'b0;
      branch_pc_q <= '0;
      result_pc_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      update_q <= update_d;
      mispredict_q <= mispredict_d;
      taken_q <= taken_d;
      branch_pc_q <= branch_pc_d;
      result_pc_q <= result_pc_d;
      underflow_q <= underflow_d;
    end
  end
  assign update = update_q;
  assign branchPC = branch_pc_q;
  assign resultPC = result_pc_q;
  assign taken = taken_q;
  assign mispredict = mispredict_q;
  assign redirect_pc = result_pc_q;
  assign underflow_err = underflow_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with hand-computed expectations
module tb_branch_resolve_unit;
  logic clk = 0, rst = 1;
  logic push = 0, push_pred_taken = 0, resolve_valid = 0, resolve_taken = 0, flush = 0;
  logic [31:0] push_pc = 0, push_pred_target = 0, resolve_target = 0;
  logic full, update, taken, mispredict, underflow_err;
  logic [31:0] branchPC, resultPC, redirect_pc;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .push(push), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
    .push_pred_target(push_pred_target), .full(full), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target), .flush(flush),
    .update(update), .branchPC(branchPC), .resultPC(resultPC), .taken(taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .underflow_err(underflow_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_rec(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    push = 1; push_pc = pc; push_pred_taken = pt; push_pred_target = tgt;
    tick();
    push = 0;
  endtask
  task automatic resolve_rec(input logic tk, input logic [31:0] tgt);
    resolve_valid = 1; resolve_taken = tk; resolve_target = tgt;
    tick();
    resolve_valid = 0;
  endtask
  initial begin
    logic [31:0] pc_k, tgt_k;
    logic tk_k;
    repeat (2) tick();
    chk("rst_update", update, 0);
    chk("rst_full", full, 0);
    chk("rst_branchpc", branchPC, 0);
    chk("rst_underflow", underflow_err, 0);
    rst = 0;
    push_rec(32'h111, 0, 32'h115);
    push_rec(32'h222, 0, 32'h226);
    resolve_rec(0, 0);
    chk("pre_async_update", update, 1);
    #2 rst = 1;
    #1;
    chk("async_update", update, 0);
    chk("async_branchpc", branchPC, 0);
    chk("async_resultpc", resultPC, 0);
    chk("async_count", dut.u_fifo.count_q, 0);
    rst = 0;
    tick();
    push_rec(32'h500, 0, 32'h504);
    chk("slot0_wr", dut.u_fifo.wr_q, 1);
    resolve_rec(0, 0);
    chk("slot0_pc", branchPC, 32'h500);
    // correct not-taken prediction
    push_rec(32'h100, 0, 32'h104);
    resolve_rec(0, 32'hdead);
    chk("ok_update", update, 1);
    chk("ok_branchpc", branchPC, 32'h100);
    chk("ok_resultpc", resultPC, 32'h104);
    chk("ok_taken", taken, 0);
    chk("ok_mis", mispredict, 0);
    tick();
    chk("ok_pulse_end", update, 0);
    chk("ok_hold", branchPC, 32'h100);
    // wrong target with two younger records and a same-cycle push
    push_rec(32'h200, 1, 32'h240);
    push_rec(32'h300, 0, 32'h304);
    push_rec(32'h400, 0, 32'h404);
    push = 1; push_pc = 32'h500; push_pred_taken = 0; push_pred_target = 32'h504;
    resolve_rec(1, 32'h280);
    push = 0;
    chk("mis_pulse", mispredict, 1);
    chk("mis_update", update, 1);
    chk("mis_redirect", redirect_pc, 32'h280);
    chk("mis_resultpc", resultPC, 32'h280);
    chk("mis_taken", taken, 1);
    chk("mis_count", dut.u_fifo.count_q, 0);
    push_rec(32'h600, 0, 32'h604);
    chk("recover_drop", dut.u_fifo.count_q, 0);
    chk("mis_pulse_end", mispredict, 0);
    push_rec(32'h700, 0, 32'h704);
    chk("run_again", dut.u_fifo.count_q, 1);
    resolve_rec(0, 0);
    chk("after_mis_pc", branchPC, 32'h700);
    chk("after_mis_ok", mispredict, 0);
    // fill, overflow drop, push+resolve while full, drain in order
    for (int i = 0; i < 8; i++) push_rec(32'h1000 + i * 16, 0, 32'h1004 + i * 16);
    chk("full_set", full, 1);
    push_rec(32'h2000, 0, 32'h2004);
    chk("ovf_count", dut.u_fifo.count_q, 8);
    push = 1; push_pc = 32'h3000; push_pred_taken = 0; push_pred_target = 32'h3004;
    resolve_rec(0, 0);
    push = 0;
    chk("full_pr_pc", branchPC, 32'h1000);
    chk("full_pr_count", dut.u_fifo.count_q, 8);
    chk("full_pr_full", full, 1);
    for (int i = 1; i < 8; i++) begin
      resolve_rec(0, 0);
      chk($sformatf("drain%0d", i), branchPC, 32'h1000 + i * 16);
    end
    resolve_rec(0, 0);
    chk("drain_last", branchPC, 32'h3000);
    chk("drain_empty", dut.u_fifo.count_q, 0);
    // streaming push/resolve pairs across pointer wrap
    push_rec(32'h4000, 0, 32'h4004);
    for (int k = 0; k < 20; k++) begin
      pc_k = 32'h4000 + (k + 1) * 8;
      tk_k = 1'((k + 1) % 2);
      push = 1; push_pc = pc_k; push_pred_taken = tk_k;
      push_pred_target = tk_k ? 32'h9000 + (k + 1) * 16 : pc_k + 4;
      pc_k = 32'h4000 + k * 8;
      tk_k = 1'(k % 2);
      tgt_k = tk_k ? 32'h9000 + k * 16 : pc_k + 4;
      resolve_rec(tk_k, tk_k ? tgt_k : 32'h0);
      push = 0;
      chk($sformatf("pair%0d_pc", k), branchPC, pc_k);
      chk($sformatf("pair%0d_res", k), resultPC, tgt_k);
      chk($sformatf("pair%0d_mis", k), mispredict, 0);
    end
    resolve_rec(0, 0);
    chk("pair_last", branchPC, 32'h4000 + 20 * 8);
    // flush with three entries and a concurrent resolve
    push_rec(32'ha00, 0, 32'ha04);
    push_rec(32'ha10, 0, 32'ha14);
    push_rec(32'ha20, 0, 32'ha24);
    flush = 1;
    resolve_rec(0, 0);
    flush = 0;
    chk("flush_update", update, 0);
    chk("flush_count", dut.u_fifo.count_q, 0);
    chk("flush_noerr", underflow_err, 0);
    // PC wrap on fall-through
    push_rec(32'hfffffffc, 0, 32'h0);
    resolve_rec(0, 0);
    chk("wrap_result", resultPC, 32'h0);
    chk("wrap_mis", mispredict, 0);
    chk("wrap_update", update, 1);
    // resolve with empty queue
    tick();
    resolve_rec(0, 0);
    chk("empty_update", update, 0);
    chk("empty_err", underflow_err, 1);
    repeat (3) tick();
    chk("err_sticky", underflow_err, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("err_cleared", underflow_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
